// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the 13-bit RISC core.
// Feeds the ALU with opcode, register addresses and immediate; owns the PC.
module ctrl_sequencer #(
  parameter int PC_W = 9
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [12:0]     i_imem_data,
  output logic [3:0]      o_alu_opcode,
  output logic [2:0]      o_rf_ra_addr,
  output logic [2:0]      o_rf_rb_addr,
  output logic            o_imm_sel,
  output logic [12:0]     o_imm,
  input  logic            i_alu_checkbranch,
  output logic            o_rf_we,
  output logic [2:0]      o_rf_wa,
  output logic [PC_W-1:0] o_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [12:0]     ir_q, ir_d;

  logic [3:0]      op;
  logic            is_nop, is_jump, is_branch, is_imm;
  logic [PC_W-1:0] pc_inc, br_tgt, j_tgt;

  assign op        = ir_q[12:9];
  assign is_nop    = (op == 4'b0000);
  assign is_jump   = (op == 4'b1000);
  assign is_branch = (op[3:2] == 2'b11);
  assign is_imm    = (op == 4'b1001) || (op == 4'b1010);

  // All PC arithmetic is modulo 2^PC_W; the casts give the wrap for free.
  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_inc + PC_W'(signed'(ir_q[2:0]));
  assign j_tgt  = PC_W'(ir_q[8:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (i_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          ir_d    = i_imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_nop) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (is_jump) begin
          pc_d    = j_tgt;
          state_d = S_FETCH;
        end else if (is_branch) begin
          pc_d    = i_alu_checkbranch ? br_tgt : pc_inc;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_imem_req   = (state_q == S_FETCH);
    o_alu_opcode = 4'b0000;
    o_rf_ra_addr = 3'd0;
    o_rf_rb_addr = 3'd0;
    o_imm_sel    = 1'b0;
    o_imm        = 13'd0;
    o_rf_we      = 1'b0;
    o_rf_wa      = 3'd0;
    // Operand fields are presented from DECODE and held through EXEC.
    if (state_q == S_DECODE || state_q == S_EXEC) begin
      if (is_branch) begin
        o_rf_ra_addr = ir_q[8:6];
        o_rf_rb_addr = ir_q[5:3];
      end else if (is_imm) begin
        o_rf_ra_addr = ir_q[5:3];
        o_imm_sel    = 1'b1;
        o_imm        = {10'd0, ir_q[2:0]};
      end else if (!is_nop && !is_jump) begin
        o_rf_ra_addr = ir_q[5:3];
        o_rf_rb_addr = ir_q[2:0];
      end
    end
    if (state_q == S_EXEC) o_alu_opcode = op;
    if (state_q == S_WB) begin
      o_rf_we = 1'b1;
      o_rf_wa = ir_q[8:6];
    end
  end

  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: hand-computed expectations for fetch wait,
// ALU/immediate write-back, branches, jumps, PC wrap and mid-fetch reset.
module tb_ctrl_sequencer;
  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [12:0]     imem_data;
  logic [3:0]      alu_opcode;
  logic [2:0]      ra, rb;
  logic            imm_sel;
  logic [12:0]     imm;
  logic            cb;
  logic            rf_we;
  logic [2:0]      rf_wa;
  logic [PC_W-1:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_sequencer #(.PC_W(PC_W)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_en              (en),
    .o_imem_req        (imem_req),
    .o_imem_addr       (imem_addr),
    .i_imem_ack        (imem_ack),
    .i_imem_data       (imem_data),
    .o_alu_opcode      (alu_opcode),
    .o_rf_ra_addr      (ra),
    .o_rf_rb_addr      (rb),
    .o_imm_sel         (imm_sel),
    .o_imm             (imm),
    .i_alu_checkbranch (cb),
    .o_rf_we           (rf_we),
    .o_rf_wa           (rf_wa),
    .o_pc              (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the DUT is in FETCH; leaves it in DECODE.
  task automatic fetch(input logic [12:0] data, input int waits);
    for (int i = 0; i < waits; i++) tick();
    imem_ack  = 1'b1;
    imem_data = data;
    tick();
    imem_ack  = 1'b0;
    imem_data = 13'd0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; imem_ack = 1'b0; imem_data = 13'd0; cb = 1'b0;
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_op", alu_opcode, 0);
    chk("rst_imm_sel", imm_sel, 0);
    chk("rst_imm", imm, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", imem_req, 0);

    // ADD r1,r2,r3 with three wait cycles
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 0);
      tick();
    end
    chk("ack_req", imem_req, 1);
    fetch(13'b0001_001_010_011, 0);
    chk("dec_op_nop", alu_opcode, 0);
    chk("dec_ra", ra, 2);
    chk("dec_rb", rb, 3);
    tick();
    chk("add_op", alu_opcode, 4'b0001);
    chk("add_ra", ra, 2);
    chk("add_rb", rb, 3);
    chk("add_sel", imm_sel, 0);
    chk("add_exec_we", rf_we, 0);
    tick();
    chk("add_we", rf_we, 1);
    chk("add_wa", rf_wa, 1);
    tick();
    chk("add_we_pulse", rf_we, 0);
    chk("add_next", imem_addr, 1);

    // ADDi r4,r5,#7
    fetch(13'b1001_100_101_111, 1);
    tick();
    chk("addi_op", alu_opcode, 4'b1001);
    chk("addi_sel", imm_sel, 1);
    chk("addi_imm", imm, 7);
    chk("addi_ra", ra, 5);
    tick();
    chk("addi_we", rf_we, 1);
    chk("addi_wa", rf_wa, 4);
    tick();
    chk("addi_next", imem_addr, 2);

    // J 5
    fetch(13'b1000_0_0000_0101, 0);
    tick();
    chk("j5_op", alu_opcode, 4'b1000);
    chk("j5_we", rf_we, 0);
    tick();
    chk("j5_next", imem_addr, 5);

    // BEQ r1,r2,-2 taken at PC=5
    fetch(13'b1100_001_010_110, 0);
    cb = 1'b1;
    tick();
    chk("beq_op", alu_opcode, 4'b1100);
    chk("beq_ra", ra, 1);
    chk("beq_rb", rb, 2);
    chk("beq_t_we", rf_we, 0);
    tick();
    cb = 1'b0;
    chk("beq_t_we2", rf_we, 0);
    chk("beq_taken", imem_addr, 4);

    // NOP at 4 returns to 5
    fetch(13'd0, 0);
    tick();
    chk("nop_op", alu_opcode, 0);
    tick();
    chk("nop_next", imem_addr, 5);

    // BEQ not taken
    fetch(13'b1100_001_010_110, 0);
    tick();
    chk("beq_nt_we", rf_we, 0);
    tick();
    chk("beq_nt_we2", rf_we, 0);
    chk("beq_not_taken", imem_addr, 6);

    // J 259
    fetch(13'b1000_1_0000_0011, 2);
    tick(); tick();
    chk("j259_next", imem_addr, 259);

    // ADD with branch flag held high: flag is ignored
    cb = 1'b1;
    fetch(13'b0001_001_010_011, 0);
    tick();
    chk("addcb_exec_we", rf_we, 0);
    tick();
    chk("addcb_we", rf_we, 1);
    chk("addcb_wa", rf_wa, 1);
    tick();
    cb = 1'b0;
    chk("addcb_next", imem_addr, 260);

    // Jump to 511, NOP wraps to 0
    fetch(13'b1000_1_1111_1111, 0);
    tick(); tick();
    chk("j511_next", imem_addr, 511);
    fetch(13'd0, 0);
    tick(); tick();
    chk("wrap_next", imem_addr, 0);

    // BNE -2 taken at PC=0 wraps to 511
    fetch(13'b1111_000_000_110, 0);
    cb = 1'b1;
    tick();
    chk("bne_op", alu_opcode, 4'b1111);
    tick();
    cb = 1'b0;
    chk("bne_wrap", imem_addr, 511);
    chk("bne_req", imem_req, 1);

    // Reset mid-fetch, then a stray ack
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc, 0);
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_data = 13'b0001_001_010_011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_req", imem_req, 0);
      chk("post_rst_we", rf_we, 0);
      chk("post_rst_op", alu_opcode, 0);
    end
    imem_ack = 1'b0;
    imem_data = 13'd0;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control sequencer for the 13-bit RISC processor; sits directly upstream of the ALU.
- Fetches instructions from instruction memory over a req/ack handshake and decodes them.
- Drives the ALU opcode, register-file read addresses and immediate operand, then schedules register write-back.
- Consumes the ALU branch flag to update the PC.

Parameters:
PC_W, 9, program counter and instruction address width (instruction space 2^PC_W words)

Ports:
i_clk  input  1  clock, rising-edge
i_rst_n  input  1  asynchronous reset, active-low
i_en  input  1  run enable; sampled only in IDLE
o_imem_req  output  1  instruction fetch request
o_imem_addr  output  PC_W  fetch address (= PC)
i_imem_ack  input  1  fetch complete; i_imem_data valid this cycle
i_imem_data  input  13  instruction word
o_alu_opcode  output  4  opcode to ALU; 4'b0000 (NOP) outside EXEC
o_rf_ra_addr  output  3  register-file read port A address
o_rf_rb_addr  output  3  register-file read port B address
o_imm_sel  output  1  1 = ALU operand B comes from o_imm, 0 = from read port B
o_imm  output  13  zero-extended immediate
i_alu_checkbranch  input  1  ALU branch-taken flag
o_rf_we  output  1  register write strobe; single-cycle pulse
o_rf_wa  output  3  write address
o_pc  output  PC_W  current PC

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, PC=0, IR=0.
  - o_imem_req=0, o_rf_we=0, o_rf_wa=0, o_alu_opcode=0, o_imm_sel=0, o_imm=0.
  - Reset mid-fetch abandons the request; an ack arriving after reset with state≠FETCH is ignored.
- Instruction formats (IR[12:9] = opcode):
  - R (ADD, SUB, MUL, DIV, AND, OR, XOR, LSL): rd=[8:6], ra=[5:3], rb=[2:0].
  - I (ADDi=1001, SUBi=1010): rd=[8:6], ra=[5:3], imm=zero-extended [2:0].
  - B (BEQ, BGT, BLT, BNE = 1100–1111): ra=[8:6], rb=[5:3], off=signed [2:0].
  - J (1000): target=[8:0], truncated or zero-extended to PC_W.
  - NOP (0000).
- States:
  - IDLE: if i_en, go to FETCH; else stay.
  - FETCH: o_imem_req=1 and o_imem_addr=PC, both held stable until i_imem_ack. On ack, IR<=i_imem_data and go to DECODE. Unbounded wait allowed.
  - DECODE: one cycle. o_rf_ra_addr, o_rf_rb_addr, o_imm and o_imm_sel are driven from IR per format and held through EXEC.
  - EXEC: one cycle. o_alu_opcode=IR[12:9].
    - R or I: go to WB.
    - NOP: PC<=PC+1, go to FETCH.
    - J, or B with i_alu_checkbranch=1: PC<=target, go to FETCH. Branch target = PC+1+sext(off).
    - B with i_alu_checkbranch=0: PC<=PC+1, go to FETCH.
    - i_alu_checkbranch is ignored for every non-branch opcode.
  - WB: o_rf_we=1 and o_rf_wa=rd for exactly one cycle; PC<=PC+1; go to FETCH.
- Latency measured from the ack cycle (ack cycle counted as cycle 1):
  - ALU op: 4 cycles (ack, DECODE, EXEC, WB).
  - Branch, jump or NOP: 3 cycles.
- PC arithmetic is modulo 2^PC_W. PC=2^PC_W-1 followed by +1 yields 0. A negative offset below 0 wraps.
- i_en is checked only in IDLE. There is no return to IDLE after leaving it, except via reset.
- o_rf_we is never asserted for NOP, J or branch instructions.

Test Plan:
- Reset then i_en=1, ack after 3 wait cycles with 0001_001_010_011 (ADD r1,r2,r3):
  - o_imem_addr=0 is held through all wait cycles.
  - EXEC: o_alu_opcode=0001, ra=2, rb=3, o_imm_sel=0.
  - WB: o_rf_we pulses with wa=1; next fetch addr=1.
- ADDi 1001_100_101_111:
  - o_imm_sel=1, o_imm=13'd7, ra=5.
  - WB: wa=4.
- At PC=5, BEQ with off=3'b110 (-2):
  - checkbranch=1 in EXEC → next fetch addr=4.
  - checkbranch=0 → next fetch addr=6.
  - No o_rf_we in either case.
- J 1000_1_0000_0011 → next fetch addr=259.
- ADD with i_alu_checkbranch held 1 → ignored; PC advances by 1 and o_rf_we pulses.
- Wrap and reset:
  - PC=511, NOP → next fetch addr=0.
  - Assert i_rst_n=0 during FETCH with req high → req drops immediately, PC=0. A later ack is ignored; the block stays in IDLE until i_en=1.
